// File: rtl/puf_pkg.sv
// Shared types and default constants for the arbiter PUF challenge sequencer.
package puf_pkg;

  localparam int DEF_CH_W       = 128;
  localparam int DEF_SETUP_CYC  = 4;
  localparam int DEF_SETTLE_CYC = 8;
  localparam int DEF_N_EVAL     = 7;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    SETTLE = 2'd2,
    DONE   = 2'd3
  } puf_state_e;

  // True when strictly more than half of n samples were 1 (n is odd).
  function automatic logic majority(input int unsigned ones, input int unsigned n);
    return ones > (n / 2);
  endfunction

endpackage

// File: rtl/puf_sync2.sv
// Two-flop synchronizer for asynchronous arbiter outputs.
module puf_sync2 #(
  parameter int W = 2
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  logic [W-1:0] meta;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta <= '0;
      q    <= '0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/puf_challenge_sequencer.sv
// Runs N_EVAL setup/launch/settle evaluations of one arbiter PUF per challenge
// and returns the majority-voted response with stability and error flags.
//
// state  | meaning
// IDLE   | waiting for a challenge, race inputs low
// SETUP  | challenge applied, race inputs low for SETUP_CYC cycles
// SETTLE | race inputs high for SETTLE_CYC cycles, sample on the last one
// DONE   | response presented until resp_ready
import puf_pkg::*;

module puf_challenge_sequencer #(
  parameter int CH_W       = DEF_CH_W,
  parameter int SETUP_CYC  = DEF_SETUP_CYC,
  parameter int SETTLE_CYC = DEF_SETTLE_CYC,
  parameter int N_EVAL     = DEF_N_EVAL,
  parameter int CNT_W      = $clog2(N_EVAL + 1)
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            ch_valid,
  output logic            ch_ready,
  input  logic [CH_W-1:0] ch_data,
  output logic [CH_W-1:0] puf_ctrl,
  output logic            puf_in0,
  output logic            puf_in1,
  input  logic            puf_out,
  input  logic            puf_out_inv,
  output logic            resp_valid,
  input  logic            resp_ready,
  output logic            resp_bit,
  output logic [CNT_W-1:0] resp_ones,
  output logic            resp_stable,
  output logic            resp_err
);

  localparam int PH_MAX = (SETUP_CYC > SETTLE_CYC) ? SETUP_CYC : SETTLE_CYC;
  localparam int PH_W   = $clog2(PH_MAX + 1);

  puf_state_e        state, state_nxt;
  logic [PH_W-1:0]   phase;
  logic [CNT_W-1:0]  eval_cnt;
  logic [CNT_W-1:0]  ones_cnt;
  logic              err;
  logic [1:0]        sync_q;
  logic              out_s, inv_s;
  logic              phase_tc;
  logic              last_eval;

  puf_sync2 #(.W(2)) u_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .d     ({puf_out_inv, puf_out}),
    .q     (sync_q)
  );

  assign out_s     = sync_q[0];
  assign inv_s     = sync_q[1];
  assign phase_tc  = (phase == '0);
  assign last_eval = (eval_cnt == CNT_W'(N_EVAL - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (ch_valid)   state_nxt = SETUP;
      SETUP:   if (phase_tc)   state_nxt = SETTLE;
      SETTLE:  if (phase_tc)   state_nxt = last_eval ? DONE : SETUP;
      DONE:    if (resp_ready) state_nxt = IDLE;
      default:                 state_nxt = IDLE;
    endcase
  end

  // Phase timer counts down to zero; each phase loads its length minus one.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      puf_ctrl <= '0;
      phase    <= '0;
      eval_cnt <= '0;
      ones_cnt <= '0;
      err      <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (ch_valid) begin
            puf_ctrl <= ch_data;
            phase    <= PH_W'(SETUP_CYC - 1);
            eval_cnt <= '0;
            ones_cnt <= '0;
            err      <= 1'b0;
          end
        end
        SETUP: begin
          if (phase_tc) phase <= PH_W'(SETTLE_CYC - 1);
          else          phase <= phase - 1'b1;
        end
        SETTLE: begin
          if (phase_tc) begin
            ones_cnt <= ones_cnt + CNT_W'(out_s);
            err      <= err | (out_s == inv_s);
            eval_cnt <= eval_cnt + 1'b1;
            phase    <= PH_W'(SETUP_CYC - 1);
          end else begin
            phase <= phase - 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  // Race inputs decode straight from state so reset drops them asynchronously.
  assign puf_in0     = (state == SETTLE);
  assign puf_in1     = (state == SETTLE);
  assign ch_ready    = (state == IDLE);
  assign resp_valid  = (state == DONE);
  assign resp_bit    = resp_valid & majority(int'(ones_cnt), N_EVAL);
  assign resp_ones   = resp_valid ? ones_cnt : '0;
  assign resp_stable = resp_valid & ((ones_cnt == '0) || (ones_cnt == CNT_W'(N_EVAL)));
  assign resp_err    = resp_valid & err;

endmodule

// File: tb/tb_puf_challenge_sequencer.sv
// Self-checking bench: table vectors, a reset-abort sequence and random patterns.
module tb_puf_challenge_sequencer;

  localparam int N_EVAL  = 7;
  localparam int SETUP   = 4;
  localparam int SETTLE  = 8;
  localparam int LATENCY = 1 + N_EVAL * (SETUP + SETTLE);

  logic         clk;
  logic         rst_n;
  logic         ch_valid;
  logic         ch_ready;
  logic [127:0] ch_data;
  logic [127:0] puf_ctrl;
  logic         puf_in0, puf_in1;
  logic         puf_out, puf_out_inv;
  logic         resp_valid;
  logic         resp_ready;
  logic         resp_bit;
  logic [2:0]   resp_ones;
  logic         resp_stable;
  logic         resp_err;

  int n_vec = 0;
  int n_err = 0;

  typedef struct {
    logic [127:0] ch;
    logic [6:0]   pat;     // bit k = arbiter result of evaluation k+1
    logic [6:0]   errpat;  // bit k set: out_inv equals out on evaluation k+1
    int           hold;
    logic [2:0]   ones;
    logic         rbit;
    logic         stable;
    logic         err;
  } vec_t;

  vec_t tbl[5];

  puf_challenge_sequencer dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .ch_valid    (ch_valid),
    .ch_ready    (ch_ready),
    .ch_data     (ch_data),
    .puf_ctrl    (puf_ctrl),
    .puf_in0     (puf_in0),
    .puf_in1     (puf_in1),
    .puf_out     (puf_out),
    .puf_out_inv (puf_out_inv),
    .resp_valid  (resp_valid),
    .resp_ready  (resp_ready),
    .resp_bit    (resp_bit),
    .resp_ones   (resp_ones),
    .resp_stable (resp_stable),
    .resp_err    (resp_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: a response is just a vote over the recorded patterns.
  function automatic vec_t model(input logic [127:0] ch, input logic [6:0] pat,
                                 input logic [6:0] errpat, input int hold);
    vec_t v;
    int ones;
    ones     = $countones(pat);
    v.ch     = ch;
    v.pat    = pat;
    v.errpat = errpat;
    v.hold   = hold;
    v.ones   = 3'(ones);
    v.rbit   = (2 * ones > N_EVAL);
    v.stable = (ones == 0) || (ones == N_EVAL);
    v.err    = (errpat != 0);
    return v;
  endfunction

  task automatic check_resp(input string tag, input vec_t v);
    check({tag, "_valid"},  resp_valid,  1'b1);
    check({tag, "_bit"},    resp_bit,    v.rbit);
    check({tag, "_ones"},   resp_ones,   v.ones);
    check({tag, "_stable"}, resp_stable, v.stable);
    check({tag, "_err"},    resp_err,    v.err);
  endtask

  // Drives one challenge, plays the PUF, checks waveform, latency and response.
  // abort_eval > 0 asserts reset three cycles into that evaluation's settle window.
  task automatic run_txn(input vec_t v, input int abort_eval);
    int idx, lo_run, hi_run, lat;
    logic prev;
    idx = 0; lo_run = 0; hi_run = 0; lat = 0; prev = 1'b0;
    @(negedge clk);
    check("ch_ready_idle", ch_ready, 1'b1);
    ch_valid = 1'b1;
    ch_data  = v.ch;
    @(negedge clk);
    ch_valid = 1'b0;
    ch_data  = ~v.ch;
    check("ctrl_latched", puf_ctrl, v.ch);
    check("ch_ready_busy", ch_ready, 1'b0);
    for (int cyc = 1; cyc <= 200; cyc++) begin
      if (cyc > 1) @(negedge clk);
      if (puf_in0 !== puf_in1) check("in0_eq_in1", puf_in1, puf_in0);
      if (puf_in0 && !prev) begin
        check("low_run", lo_run, SETUP);
        lo_run = 0;
        idx++;
        if (idx <= N_EVAL) begin
          puf_out     = v.pat[idx-1];
          puf_out_inv = v.errpat[idx-1] ? v.pat[idx-1] : ~v.pat[idx-1];
        end
      end else if (!puf_in0 && prev) begin
        check("high_run", hi_run, SETTLE);
        hi_run = 0;
      end
      if (puf_in0) begin
        hi_run++;
        if (puf_ctrl !== v.ch) check("ctrl_stable_high", puf_ctrl, v.ch);
      end else begin
        lo_run++;
      end
      prev = puf_in0;
      if (abort_eval > 0 && idx == abort_eval && hi_run == 3) begin
        rst_n = 1'b0;
        #1;
        check("rst_in0",     puf_in0,    1'b0);
        check("rst_in1",     puf_in1,    1'b0);
        check("rst_ctrl",    puf_ctrl,   128'd0);
        check("rst_valid",   resp_valid, 1'b0);
        check("rst_chready", ch_ready,   1'b1);
        @(negedge clk);
        rst_n       = 1'b1;
        puf_out     = 1'b0;
        puf_out_inv = 1'b1;
        return;
      end
      if (resp_valid) begin
        lat = cyc;
        break;
      end
    end
    check("latency", lat, LATENCY);
    check("eval_count", idx, N_EVAL);
    check_resp("resp", v);
    for (int h = 1; h <= v.hold; h++) begin
      ch_valid = (h == 3);
      ch_data  = {$urandom, $urandom, $urandom, $urandom};
      @(negedge clk);
      check_resp("hold", v);
      check("hold_chready", ch_ready, 1'b0);
    end
    ch_valid = 1'b0;
    check("ctrl_kept", puf_ctrl, v.ch);
    resp_ready = 1'b1;
    @(negedge clk);
    resp_ready = 1'b0;
    check("post_chready", ch_ready,   1'b1);
    check("post_valid",   resp_valid, 1'b0);
    check("post_ones",    resp_ones,  3'd0);
    check("post_bit",     resp_bit,   1'b0);
    check("post_stable",  resp_stable, 1'b0);
    check("post_err",     resp_err,   1'b0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    tbl[0] = '{128'hc71f2e46cc9dc3bfdd47048bc4bdce79, 7'b1111111, 7'b0000000, 0, 3'd7, 1'b1, 1'b1, 1'b0};
    tbl[1] = '{128'h0123456789abcdef_fedcba9876543210, 7'b0101101, 7'b0000000, 0, 3'd4, 1'b1, 1'b0, 1'b0};
    tbl[2] = '{128'hdeadbeef_00000000_cafef00d_12345678, 7'b0100100, 7'b0000000, 0, 3'd2, 1'b0, 1'b0, 1'b0};
    tbl[3] = '{128'h5a5a5a5a_a5a5a5a5_0f0f0f0f_f0f0f0f0, 7'b0000100, 7'b0000100, 0, 3'd1, 1'b0, 1'b0, 1'b1};
    tbl[4] = '{128'h11111111_22222222_33333333_44444444, 7'b0000000, 7'b0000000, 10, 3'd0, 1'b0, 1'b1, 1'b0};

    rst_n       = 1'b0;
    ch_valid    = 1'b0;
    ch_data     = '0;
    resp_ready  = 1'b0;
    puf_out     = 1'b0;
    puf_out_inv = 1'b1;
    #2;
    check("reset_chready", ch_ready,    1'b1);
    check("reset_valid",   resp_valid,  1'b0);
    check("reset_in0",     puf_in0,     1'b0);
    check("reset_in1",     puf_in1,     1'b0);
    check("reset_ctrl",    puf_ctrl,    128'd0);
    check("reset_ones",    resp_ones,   3'd0);
    check("reset_stable",  resp_stable, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 5; i++) run_txn(tbl[i], 0);

    run_txn(model(128'hfeedface_0badf00d_8badf00d_abad1dea, 7'b1011011, 7'b0, 0), 4);
    run_txn(tbl[0], 0);

    for (int i = 0; i < 6; i++) begin
      logic [6:0] pat, errpat;
      pat    = 7'($urandom);
      errpat = 7'($urandom & $urandom & $urandom);
      run_txn(model({$urandom, $urandom, $urandom, $urandom}, pat, errpat,
                    int'($urandom_range(0, 3))), 0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
